// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, condition-code bit positions
// and default datapath geometry.
package cpu_pkg;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 4;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_PADDSB = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_AND    = 4'b0011;
    localparam logic [3:0] OP_NOR    = 4'b0100;
    localparam logic [3:0] OP_SLL    = 4'b0101;
    localparam logic [3:0] OP_SRL    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;

    localparam int FLG_Z = 0;
    localparam int FLG_V = 1;
    localparam int FLG_N = 2;

endpackage

// File: rtl/flag_reg.sv
// Condition-code register (Z, V, N) with opcode-class update decode.
// Build option FLAG_FWD_EN: when defined, the flag outputs present the
// next-flag value combinationally so a dependent branch needs no bubble.
module flag_reg
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,
    input  logic [3:0] opcode,
    input  logic       alu_zr,
    input  logic       alu_ov,
    input  logic       alu_neg,
    output logic       flag_z,
    output logic       flag_v,
    output logic       flag_n
);

    logic [2:0] flags_q;
    logic [2:0] flags_next;
    logic       updates_all;
    logic       updates_z;

    // Opcode class decode and next-flag computation.
    always_comb begin
        updates_all = (opcode == OP_ADD) || (opcode == OP_SUB);
        updates_z   = (opcode == OP_AND) || (opcode == OP_NOR) ||
                      (opcode == OP_SLL) || (opcode == OP_SRL) ||
                      (opcode == OP_SRA);
        flags_next  = flags_q;
        if (accept && updates_all) begin
            flags_next[FLG_Z] = alu_zr;
            flags_next[FLG_V] = alu_ov;
            flags_next[FLG_N] = alu_neg;
        end else if (accept && updates_z) begin
            flags_next[FLG_Z] = alu_zr;
        end
    end

    // Flag register; accept already excludes stall, flush and bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_next;
        end
    end

`ifdef FLAG_FWD_EN
    assign flag_z = flags_next[FLG_Z];
    assign flag_v = flags_next[FLG_V];
    assign flag_n = flags_next[FLG_N];
`else
    assign flag_z = flags_q[FLG_Z];
    assign flag_v = flags_q[FLG_V];
    assign flag_n = flags_q[FLG_N];
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result, destination, memory
// controls and store data, and owns the architectural flags via flag_reg.
// Build option FLAG_FWD_EN selects combinational flag forwarding.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] alu_dst,
    input  logic          alu_ov,
    input  logic          alu_zr,
    input  logic          alu_neg,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_we,
    input  logic          ex_mem_re,
    input  logic          ex_mem_we,
    input  logic [DW-1:0] ex_store_data,
    input  logic          mem_stall,
    input  logic          flush,
    output logic          ex_ready,
    output logic          mem_valid,
    output logic [DW-1:0] mem_alu_res,
    output logic [RW-1:0] mem_rd,
    output logic          mem_we,
    output logic          mem_re,
    output logic          mem_wr,
    output logic [DW-1:0] mem_store_data,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n
);

    logic          accept;
    logic          valid_q;
    logic [DW-1:0] res_q;
    logic [RW-1:0] rd_q;
    logic          we_q;
    logic          re_q;
    logic          wr_q;
    logic [DW-1:0] sd_q;

    assign ex_ready = !mem_stall;
    assign accept   = ex_valid && ex_ready && !flush;

    // Pipeline register: stall holds everything, flush only clears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            wr_q    <= 1'b0;
            sd_q    <= '0;
        end else if (!mem_stall) begin
            valid_q <= ex_valid && !flush;
            res_q   <= alu_dst;
            rd_q    <= ex_rd;
            we_q    <= ex_we;
            re_q    <= ex_mem_re;
            wr_q    <= ex_mem_we;
            sd_q    <= ex_store_data;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_alu_res    = res_q;
    assign mem_rd         = rd_q;
    assign mem_store_data = sd_q;
    assign mem_we         = valid_q && we_q;
    assign mem_re         = valid_q && re_q;
    assign mem_wr         = valid_q && wr_q;

    flag_reg u_flag_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .accept  (accept),
        .opcode  (ex_opcode),
        .alu_zr  (alu_zr),
        .alu_ov  (alu_ov),
        .alu_neg (alu_neg),
        .flag_z  (flag_z),
        .flag_v  (flag_v),
        .flag_n  (flag_n)
    );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios followed by
// randomized traffic, compared against a behavioural reference model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] alu_dst;
    logic        alu_ov, alu_zr, alu_neg;
    logic [3:0]  ex_rd;
    logic        ex_we, ex_mem_re, ex_mem_we;
    logic [15:0] ex_store_data;
    logic        mem_stall, flush;
    logic        ex_ready, mem_valid;
    logic [15:0] mem_alu_res, mem_store_data;
    logic [3:0]  mem_rd;
    logic        mem_we, mem_re, mem_wr;
    logic        flag_z, flag_v, flag_n;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic        m_valid;
    logic [15:0] m_res, m_sd;
    logic [3:0]  m_rd;
    logic        m_we, m_re, m_wr;
    logic        m_z, m_v, m_n;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .alu_dst(alu_dst), .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_neg(alu_neg),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
        .ex_store_data(ex_store_data), .mem_stall(mem_stall), .flush(flush),
        .ex_ready(ex_ready), .mem_valid(mem_valid), .mem_alu_res(mem_alu_res),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_re(mem_re), .mem_wr(mem_wr),
        .mem_store_data(mem_store_data), .flag_z(flag_z), .flag_v(flag_v),
        .flag_n(flag_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic zr, input logic ng,
                         input logic [3:0] rd, input logic we, input logic re,
                         input logic wr, input logic [15:0] sd,
                         input logic st, input logic fl);
        ex_valid = v; ex_opcode = op; alu_dst = res; alu_ov = ov; alu_zr = zr;
        alu_neg = ng; ex_rd = rd; ex_we = we; ex_mem_re = re; ex_mem_we = wr;
        ex_store_data = sd; mem_stall = st; flush = fl;
    endtask

    task automatic model_reset();
        m_valid = 0; m_res = 0; m_sd = 0; m_rd = 0;
        m_we = 0; m_re = 0; m_wr = 0; m_z = 0; m_v = 0; m_n = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, {31'd0, mem_valid}, {31'd0, m_valid});
        chk({tag, ".we"}, {31'd0, mem_we}, {31'd0, m_valid & m_we});
        chk({tag, ".re"}, {31'd0, mem_re}, {31'd0, m_valid & m_re});
        chk({tag, ".wr"}, {31'd0, mem_wr}, {31'd0, m_valid & m_wr});
        if (m_valid) begin
            chk({tag, ".res"}, {16'd0, mem_alu_res}, {16'd0, m_res});
            chk({tag, ".rd"}, {28'd0, mem_rd}, {28'd0, m_rd});
            chk({tag, ".sd"}, {16'd0, mem_store_data}, {16'd0, m_sd});
        end
        chk({tag, ".flags"}, {29'd0, flag_n, flag_v, flag_z}, {29'd0, m_n, m_v, m_z});
    endtask

    // One clock: inputs already driven at negedge. Checks ex_ready and the
    // flag outputs before the edge, advances the model, checks after.
    task automatic step(input string tag);
        logic acc, all_f, z_f;
        logic nz, nv, nn;
        #1;
        acc   = ex_valid && !mem_stall && !flush;
        all_f = (ex_opcode == 4'd0) || (ex_opcode == 4'd2);
        z_f   = (ex_opcode >= 4'd3) && (ex_opcode <= 4'd7);
        nz = m_z; nv = m_v; nn = m_n;
        if (acc && all_f) begin nz = alu_zr; nv = alu_ov; nn = alu_neg; end
        else if (acc && z_f) nz = alu_zr;
        chk({tag, ".ready"}, {31'd0, ex_ready}, {31'd0, !mem_stall});
`ifdef FLAG_FWD_EN
        chk({tag, ".fwd"}, {29'd0, flag_n, flag_v, flag_z}, {29'd0, nn, nv, nz});
`else
        chk({tag, ".fwd"}, {29'd0, flag_n, flag_v, flag_z}, {29'd0, m_n, m_v, m_z});
`endif
        @(posedge clk);
        if (!mem_stall) begin
            m_valid = ex_valid && !flush;
            m_res = alu_dst; m_rd = ex_rd; m_sd = ex_store_data;
            m_we = ex_we; m_re = ex_mem_re; m_wr = ex_mem_we;
        end
        m_z = nz; m_v = nv; m_n = nn;
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic [15:0] r16;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        check_outputs("reset_idle");

        // load something, then asynchronous reset mid-cycle with all inputs nonzero
        drive(1, 4'd0, 16'h1234, 1, 1, 1, 4'd5, 1, 1, 1, 16'hBEEF, 0, 0);
        step("pre_reset");
        drive(1, 4'd2, 16'hFFFF, 1, 1, 1, 4'hF, 1, 1, 1, 16'hFFFF, 1, 1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_outputs("reset_async");
        @(negedge clk);
        rst_n = 1;

        // ADD overflow
        drive(1, 4'd0, 16'h8000, 1, 0, 1, 4'd3, 1, 0, 0, 16'h0000, 0, 0);
        step("add_ov");
        // AND sets Z only
        drive(1, 4'd3, 16'h0000, 0, 1, 0, 4'd4, 1, 0, 0, 16'h0000, 0, 0);
        step("and_z");
        // SUB, then three stall cycles with new EX inputs
        drive(1, 4'd2, 16'h0001, 0, 0, 0, 4'd6, 1, 0, 0, 16'h0000, 0, 0);
        step("sub_load");
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd0, 16'hAAAA, 1, 1, 1, 4'd9, 0, 1, 0, 16'h5555, 1, 0);
            step("stall_hold");
        end
        drive(1, 4'd0, 16'hAAAA, 1, 1, 1, 4'd9, 0, 1, 0, 16'h5555, 0, 0);
        step("stall_release");
        // flushed SW
        drive(1, 4'd9, 16'h0040, 0, 0, 0, 4'd0, 0, 0, 1, 16'h7777, 0, 1);
        step("flush_sw");
        // valid store, then flush+stall together
        drive(1, 4'd9, 16'h0042, 0, 0, 0, 4'd0, 0, 0, 1, 16'h1111, 0, 0);
        step("sw_load");
        drive(1, 4'd0, 16'h0000, 0, 1, 0, 4'd1, 1, 0, 0, 16'h2222, 1, 1);
        step("flush_stall");
        // bubble with flag-like inputs must not change flags
        drive(0, 4'd0, 16'h0000, 0, 0, 0, 4'd1, 1, 1, 1, 16'h0, 0, 0);
        step("bubble");
        // PADDSB and LW leave flags
        drive(1, 4'd1, 16'h0000, 0, 0, 0, 4'd1, 1, 0, 0, 16'h0, 0, 0);
        step("paddsb");
        drive(1, 4'd8, 16'h0010, 1, 0, 1, 4'd2, 1, 1, 0, 16'h0, 0, 0);
        step("lw");
        // SUB zero: forward visibility of Z
        drive(1, 4'd2, 16'h0000, 0, 1, 0, 4'd7, 1, 0, 0, 16'h0, 0, 0);
        step("sub_zero");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            r16 = 16'($urandom);
            drive(($urandom_range(0, 3) != 0), 4'($urandom), r16,
                  1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
            step("rand");
            if (i == 150) begin
                // reset while stalled
                drive(1, 4'd0, 16'hFFFF, 1, 1, 1, 4'hF, 1, 1, 1, 16'hFFFF, 1, 0);
                #2 rst_n = 0;
                #1;
                model_reset();
                check_outputs("reset_stall");
                @(negedge clk);
                rst_n = 1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
